tmm_result_collector: RTL

Consumer-side companion to the tensor-matrix multiply datapath. The block receives the stream of signed 32-bit partial products and accumulates each group of K_DIM beats into one output element C[b][i][j]. It tags every element with its tensor indices, buffers finished elements in a small FIFO, and presents them on a valid/ready result port. It applies backpressure upstream, saturates results to 32 bits, and signals completion of a full B_DIM×I_DIM×J_DIM tensor.

---
 rtl/tmm_result_collector.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tmm_result_collector.sv
// Tensor-multiply result collector: K_DIM-beat accumulation, index tagging,
// saturation and a first-word-fall-through output FIFO.
module tmm_result_collector #(
  parameter int K_DIM      = 4,
  parameter int J_DIM      = 2,
  parameter int I_DIM      = 2,
  parameter int B_DIM      = 2,
  parameter int ACC_W      = 48,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [31:0]      data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [31:0]      result,
  output logic [IDX_W-1:0] out_b,
  output logic [IDX_W-1:0] out_i,
  output logic [IDX_W-1:0] out_j,
  output logic             out_last,
  output logic             sat_flag,
  output logic             done
);

  localparam int KW = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [KW-1:0]    K_LAST = KW'(K_DIM - 1);
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(J_DIM - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(I_DIM - 1);
  localparam logic [IDX_W-1:0] B_LAST = IDX_W'(B_DIM - 1);
  localparam logic [AW:0]      FULL   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0]      res;
    logic [IDX_W-1:0] b;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic             last;
  } entry_t;

  state_t                   state;
  logic [KW-1:0]            k;
  logic [IDX_W-1:0]         b, i, j;
  logic signed [ACC_W-1:0]  acc;

  entry_t                   mem [FIFO_DEPTH];
  logic [AW-1:0]            wptr, rptr;
  logic [AW:0]              count;

  logic                     accept, push, pop;
  logic                     grp_end, tensor_end, ovf;
  logic signed [ACC_W-1:0]  ext, sum;
  logic [ACC_W-32:0]        top;
  logic [31:0]              sat_val;
  entry_t                   head;

  always_comb begin
    ext     = {{(ACC_W-32){data_in[31]}}, data_in};
    sum     = (k == '0) ? ext : acc + ext;
    top     = sum[ACC_W-1:31];
    // Upper bits not all equal means the value leaves the 32-bit range.
    ovf     = !((&top) || !(|top));
    sat_val = sum[31:0];
    if (ovf)
      sat_val = sum[ACC_W-1] ? 32'h8000_0000 : 32'h7fff_ffff;
  end

  assign ready_in   = (state != DRAIN) && (count != FULL);
  assign accept     = valid_in && ready_in;
  assign grp_end    = (k == K_LAST);
  assign push       = accept && grp_end;
  assign tensor_end = (b == B_LAST) && (i == I_LAST)
                   && (j == J_LAST);

  assign head      = mem[rptr];
  assign valid_out = (count != '0);
  assign pop       = valid_out && ready_out;

  assign result   = valid_out ? head.res : '0;
  assign out_b    = valid_out ? head.b : '0;
  assign out_i    = valid_out ? head.i : '0;
  assign out_j    = valid_out ? head.j : '0;
  assign out_last = valid_out && head.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      b        <= '0;
      i        <= '0;
      j        <= '0;
      acc      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      sat_flag <= 1'b0;
      done     <= 1'b0;
      for (int n = 0; n < FIFO_DEPTH; n++)
        mem[n] <= '0;
    end else if (clear) begin
      state    <= IDLE;
      k        <= '0;
      b        <= '0;
      i        <= '0;
      j        <= '0;
      acc      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      sat_flag <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      if (accept) begin
        if (grp_end) begin
          k         <= '0;
          acc       <= '0;
          mem[wptr] <= '{sat_val, b, i, j, tensor_end};
          wptr      <= wptr + 1'b1;
          if (ovf)
            sat_flag <= 1'b1;
          if (j == J_LAST) begin
            j <= '0;
            if (i == I_LAST) begin
              i <= '0;
              b <= (b == B_LAST) ? '0 : b + 1'b1;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end else begin
          acc <= sum;
          k   <= k + 1'b1;
        end
      end

      if (pop)
        rptr <= rptr + 1'b1;

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      unique case (state)
        IDLE: begin
          if (accept)
            state <= (push && tensor_end) ? DRAIN : ACCUM;
        end
        ACCUM: begin
          if (push && tensor_end)
            state <= DRAIN;
        end
        DRAIN: begin
          if (pop && head.last) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
